rv32i_decoder: RTL and testbench

- Decode stage of the RV32I pipeline, between fetch and register-read/execute.
- Splits a 32-bit RV32I instruction into register indices with valid flags, opcode class, funct3, funct7 and a sign-extended immediate.
- All decoded outputs are registered, giving one cycle of latency.
- Honours a pipeline-wide stall and reports its own stall upstream.

---
 rtl/rv32i_decoder.sv | 153 +++++++++++++++
 tb/tb_rv32i_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: RV32I decode stage, between fetch and register read.
//
// Splits a 32-bit instruction into register indices with valid flags, the
// opcode class, funct3/funct7 and a 21-bit sign-extended immediate. Every
// decoded output is registered, so results appear one cycle after the
// instruction is sampled. A pipeline-wide stall freezes the output register.
//
// Ports:
//   clk              system clock, all state on the rising edge
//   reset            synchronous active-high reset, clears all outputs
//   instruction      instruction word from fetch
//   system_stall     pipeline stall; holds outputs and ignores instruction
//   rs1/rs2/rd       register indices, 0 whenever the matching valid is 0
//   rs1_valid/rs2_valid/rd_valid  register use flags
//   instruction_type opcode field inst[6:0]
//   funct3/funct7    function fields where the format defines them, else 0
//   immediate        format-dependent immediate, sign-extended to bit 20
//   decoder_stall    combinational copy of system_stall
//
// Optional build macro DECODER_X0_SUPPRESS_EN: when defined, an instruction
// whose rd field is x0 reports rd_valid=0 (writes to x0 are dropped here).
module rv32i_decoder #(
  parameter int INST_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INST_WIDTH-1:0]     instruction,
  input  logic                      system_stall,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic                      rs1_valid,
  output logic                      rs2_valid,
  output logic                      rd_valid,
  output logic [6:0]                instruction_type,
  output logic [2:0]                funct3,
  output logic [6:0]                funct7,
  output logic [20:0]               immediate,
  output logic                      decoder_stall
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rs1_valid;
    logic                      rs2_valid;
    logic                      rd_valid;
    logic [6:0]                itype;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [20:0]               imm;
  } dec_t;

  dec_t        dec_d, dec_q;
  logic [31:0] inst;

  assign inst = instruction[31:0];

  always_comb begin
    dec_d       = '0;
    dec_d.itype = inst[6:0];
    case (inst[6:0])
      OP_R: begin
        dec_d.rs1_valid = 1'b1;
        dec_d.rs2_valid = 1'b1;
        dec_d.rd_valid  = 1'b1;
        dec_d.funct3    = inst[14:12];
        dec_d.funct7    = inst[31:25];
      end
      OP_IMM: begin
        dec_d.rs1_valid = 1'b1;
        dec_d.rd_valid  = 1'b1;
        dec_d.funct3    = inst[14:12];
        dec_d.imm       = {{9{inst[31]}}, inst[31:20]};
        // Only shifts carry a real funct7 (SRLI/SRAI select bit); for the
        // rest inst[31:25] is immediate data and must not leak out.
        if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101)
          dec_d.funct7 = inst[31:25];
      end
      OP_LOAD, OP_JALR: begin
        dec_d.rs1_valid = 1'b1;
        dec_d.rd_valid  = 1'b1;
        dec_d.funct3    = inst[14:12];
        dec_d.imm       = {{9{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        dec_d.rs1_valid = 1'b1;
        dec_d.rs2_valid = 1'b1;
        dec_d.funct3    = inst[14:12];
        dec_d.imm       = {{9{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        dec_d.rs1_valid = 1'b1;
        dec_d.rs2_valid = 1'b1;
        dec_d.funct3    = inst[14:12];
        dec_d.imm       = {{8{inst[31]}}, inst[31], inst[7], inst[30:25],
                           inst[11:8], 1'b0};
      end
      OP_JAL: begin
        dec_d.rd_valid = 1'b1;
        dec_d.imm      = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_d.rd_valid = 1'b1;
        // 20-bit upper immediate, bit 20 carries the sign.
        dec_d.imm      = {inst[31], inst[31:12]};
      end
      default: ;  // unknown opcode decodes as a bubble
    endcase

`ifdef DECODER_X0_SUPPRESS_EN
    if (inst[11:7] == 5'd0)
      dec_d.rd_valid = 1'b0;
`endif

    dec_d.rs1 = dec_d.rs1_valid ? inst[19:15] : '0;
    dec_d.rs2 = dec_d.rs2_valid ? inst[24:20] : '0;
    dec_d.rd  = dec_d.rd_valid  ? inst[11:7]  : '0;
  end

  // Reset wins over stall; a stall simply skips the capture.
  always_ff @(posedge clk) begin
    if (reset)
      dec_q <= '0;
    else if (!system_stall)
      dec_q <= dec_d;
  end

  assign rs1              = dec_q.rs1;
  assign rs2              = dec_q.rs2;
  assign rd               = dec_q.rd;
  assign rs1_valid        = dec_q.rs1_valid;
  assign rs2_valid        = dec_q.rs2_valid;
  assign rd_valid         = dec_q.rd_valid;
  assign instruction_type = dec_q.itype;
  assign funct3           = dec_q.funct3;
  assign funct7           = dec_q.funct7;
  assign immediate        = dec_q.imm;
  assign decoder_stall    = system_stall;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Bench for rv32i_decoder: directed sequences from the bring-up plan plus
// randomized instructions, stalls and resets, checked against a format-level
// reference model that builds immediates as integers.
module tb_rv32i_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        system_stall;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_valid, rs2_valid, rd_valid;
  logic [6:0]  instruction_type;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [20:0] immediate;
  logic        decoder_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_decoder dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .system_stall(system_stall),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .rd_valid(rd_valid),
    .instruction_type(instruction_type), .funct3(funct3), .funct7(funct7),
    .immediate(immediate), .decoder_stall(decoder_stall)
  );

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic        v1, v2, vd;
    logic [6:0]  typ;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [20:0] imm;
  } exp_t;

  exp_t exp_q = '0;

`ifdef DECODER_X0_SUPPRESS_EN
  localparam bit X0_SUP = 1'b1;
`else
  localparam bit X0_SUP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: classify into an instruction format, then compute the
  // immediate as a signed integer value and keep its low 21 bits.
  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t e;
    byte  fmt;
    int   v;
    e = '0;
    e.typ = i[6:0];
    case (i[6:0])
      7'h33:               fmt = "R";
      7'h13, 7'h03, 7'h67: fmt = "I";
      7'h23:               fmt = "S";
      7'h63:               fmt = "B";
      7'h6f:               fmt = "J";
      7'h37, 7'h17:        fmt = "U";
      default:             fmt = "-";
    endcase
    e.v1 = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
    e.v2 = (fmt == "R" || fmt == "S" || fmt == "B");
    e.vd = (fmt == "R" || fmt == "I" || fmt == "J" || fmt == "U");
    if (X0_SUP && i[11:7] == 5'd0) e.vd = 1'b0;
    if (e.v1) e.rs1 = i[19:15];
    if (e.v2) e.rs2 = i[24:20];
    if (e.vd) e.rd  = i[11:7];
    if (e.v1) e.f3 = i[14:12];
    if (fmt == "R") e.f7 = i[31:25];
    if (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) e.f7 = i[31:25];
    v = 0;
    case (fmt)
      "I": v = int'($signed(i[31:20]));
      "S": v = int'($signed({i[31:25], i[11:7]}));
      "B": v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
               + int'(i[11:8]) * 2;
      "J": v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096
               + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      "U": v = int'(i[31:12]) + int'(i[31]) * (1 << 20);
      default: v = 0;
    endcase
    e.imm = v[20:0];
    return e;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".rs1"},  32'(rs1),              32'(exp_q.rs1));
    chk({tag, ".rs2"},  32'(rs2),              32'(exp_q.rs2));
    chk({tag, ".rd"},   32'(rd),               32'(exp_q.rd));
    chk({tag, ".v1"},   32'(rs1_valid),        32'(exp_q.v1));
    chk({tag, ".v2"},   32'(rs2_valid),        32'(exp_q.v2));
    chk({tag, ".vd"},   32'(rd_valid),         32'(exp_q.vd));
    chk({tag, ".type"}, 32'(instruction_type), 32'(exp_q.typ));
    chk({tag, ".f3"},   32'(funct3),           32'(exp_q.f3));
    chk({tag, ".f7"},   32'(funct7),           32'(exp_q.f7));
    chk({tag, ".imm"},  32'(immediate),        32'(exp_q.imm));
  endtask

  // Drive one cycle, check the combinational stall echo, then the
  // registered outputs just after the edge.
  task automatic step(input string tag, input logic [31:0] ins,
                      input logic stl, input logic rst);
    instruction  = ins;
    system_stall = stl;
    reset        = rst;
    #1;
    chk({tag, ".dstall"}, 32'(decoder_stall), 32'(stl));
    @(posedge clk);
    #1;
    if (rst)       exp_q = '0;
    else if (!stl) exp_q = ref_dec(ins);
    compare_all(tag);
  endtask

  logic [6:0] op_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                             7'h67, 7'h6f, 7'h37, 7'h17};

  initial begin
    logic [31:0] r, ins;
    reset = 1'b1; system_stall = 1'b0; instruction = 32'h0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) step("reset", 32'h00208233, 1'b0, 1'b1);
    chk("reset.imm_zero",  32'(immediate),        32'd0);
    chk("reset.type_zero", 32'(instruction_type), 32'd0);

    step("add", 32'h00208233, 1'b0, 1'b0);
    chk("add.rs1_k", 32'(rs1), 32'd1);
    chk("add.rs2_k", 32'(rs2), 32'd2);
    chk("add.rd_k",  32'(rd),  32'd4);
    step("addi", 32'h00008213, 1'b0, 1'b0);
    step("lw",   32'h0000A203, 1'b0, 1'b0);
    chk("lw.f3_k", 32'(funct3), 32'd2);
    step("sw",   32'h00209223, 1'b0, 1'b0);
    chk("sw.imm_k", 32'(immediate), 32'd4);
    step("beq",  32'h00208263, 1'b0, 1'b0);
    chk("beq.imm_k", 32'(immediate), 32'd4);
    step("lui",  32'h00001037, 1'b0, 1'b0);
    chk("lui.imm_k", 32'(immediate), 32'd1);
    step("auipc", 32'h00001017, 1'b0, 1'b0);
    step("jal",  32'h0000106F, 1'b0, 1'b0);
    chk("jal.imm_k", 32'(immediate), 32'd4096);
    chk("jal.vd_k",  32'(rd_valid),  X0_SUP ? 32'd0 : 32'd1);
    step("jalr", 32'h00008267, 1'b0, 1'b0);
    // Negative immediates and shift funct7 corner cases.
    step("srai",  32'h4030D213, 1'b0, 1'b0);
    step("bneg",  32'hFE209EE3, 1'b0, 1'b0);
    step("jneg",  32'hFFFFF0EF, 1'b0, 1'b0);
    step("unk",   32'hFFFFFFFF, 1'b0, 1'b0);

    // Stall holds ADD while SW is presented, then SW lands after release.
    step("st_add", 32'h00208233, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step("st_hold", 32'h00209223, 1'b1, 1'b0);
    chk("st_hold.rd_k", 32'(rd), 32'd4);
    step("st_rel", 32'h00209223, 1'b0, 1'b0);
    chk("st_rel.vd_k", 32'(rd_valid), 32'd0);
    step("st_pre", 32'h00208233, 1'b0, 1'b0);
    step("st_rst", 32'h00208233, 1'b1, 1'b1);
    chk("st_rst.v1_k", 32'(rs1_valid), 32'd0);

    for (int n = 0; n < 400; n++) begin
      r   = $urandom();
      ins = r;
      if ($urandom_range(0, 9) != 0) ins[6:0] = op_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      step("rand", ins, ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
